tile_sequencer: RTL and testbench

TILE_SEQUENCER -- requirements
Module: tile_sequencer

---
 rtl/TicSAT_pkg.sv | 32 +++
 rtl/result_fifo2.sv | 51 +++++
 rtl/tile_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_tile_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/TicSAT_pkg.sv
// Shared types for the TicSAT systolic-array tile sequencer: accelerator
// command encoding, sequencer states and the result-FIFO credit rule.
package TicSAT_pkg;

    typedef enum logic [2:0] {
        CMD_NONE          = 3'd0,
        CMD_WRITE_WEIGHTS = 3'd1,
        CMD_WRITE_INPUT   = 3'd2,
        CMD_STREAM        = 3'd3,
        CMD_READ_OUTPUT   = 3'd4
    } command_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        LOAD_ROW = 3'd2,
        STEP     = 3'd3,
        READ     = 3'd4,
        DRAIN    = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    // A read may only be issued if the 2-entry FIFO can absorb it together
    // with the read already in flight.
    function automatic logic read_slot_free(input logic [1:0] occ, input logic inflight);
        return (occ == 2'd0) || ((occ == 2'd1) && !inflight);
    endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry result FIFO between the accelerator read port and the result
// stream; simultaneous push and pop are allowed at any non-empty occupancy.
module result_fifo2
    import TicSAT_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign do_pop    = out_valid && out_ready;
    assign do_push   = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tile_sequencer.sv
// Sequences one systolic-array job: weight load, per-row input load / step /
// result read, zero flush rows, then drains the result FIFO.
//
//   state    | meaning
//   IDLE     | waiting for start
//   LOAD_W   | streaming SA_SIZE*SA_SIZE weights into the array
//   LOAD_ROW | writing one activation row (real from stream, flush as zeros)
//   STEP     | one CMD_STREAM pulse
//   READ     | reading SA_SIZE outputs, credit-limited by the result FIFO
//   DRAIN    | waiting for the FIFO and any in-flight read to empty
//   DONE     | one-cycle done pulse
module tile_sequencer
    import TicSAT_pkg::*;
#(
    parameter int SA_SIZE    = 4,
    parameter int FLUSH_ROWS = 2 * SA_SIZE - 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_rows,
    output logic                       busy,
    output logic                       done,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          res_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_W-1:0]          sa_in_val,
    output logic [$clog2(SA_SIZE)-1:0] sa_in_idx,
    output command_t                   sa_cmd,
    input  logic [DATA_W-1:0]          sa_out
);

    localparam int IW = $clog2(SA_SIZE);
    localparam logic [IW-1:0]    COL_LAST   = IW'(SA_SIZE - 1);
    localparam logic [CNT_W-1:0] W_LAST     = CNT_W'(SA_SIZE * SA_SIZE - 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_ROWS);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] real_left;
    logic [CNT_W-1:0] flush_left;
    logic [IW-1:0]    col;
    logic             rd_inflight;
    logic [1:0]       fifo_count;

    logic             real_row;
    logic             rows_remain;
    logic             w_take;
    logic             col_adv;
    logic             rd_issue;

    assign real_row    = (real_left != '0);
    assign rows_remain = (real_left != '0) || (flush_left != '0);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        sa_cmd    = CMD_NONE;
        sa_in_val = '0;
        sa_in_idx = '0;
        w_take    = 1'b0;
        col_adv   = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD_W;
                end
            end
            LOAD_W: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_take    = 1'b1;
                    sa_cmd    = CMD_WRITE_WEIGHTS;
                    sa_in_val = in_data;
                    if (w_cnt == W_LAST) begin
                        state_nxt = real_row ? LOAD_ROW : DONE;
                    end
                end
            end
            LOAD_ROW: begin
                // Flush rows never touch the input stream; zeros are sourced here.
                if (real_row) begin
                    in_ready = 1'b1;
                    col_adv  = in_valid;
                end else begin
                    col_adv  = 1'b1;
                end
                if (col_adv) begin
                    sa_cmd    = CMD_WRITE_INPUT;
                    sa_in_idx = col;
                    sa_in_val = real_row ? in_data : '0;
                    if (col == COL_LAST) begin
                        state_nxt = STEP;
                    end
                end
            end
            STEP: begin
                sa_cmd    = CMD_STREAM;
                state_nxt = READ;
            end
            READ: begin
                if (read_slot_free(fifo_count, rd_inflight)) begin
                    rd_issue  = 1'b1;
                    sa_cmd    = CMD_READ_OUTPUT;
                    sa_in_idx = col;
                    if (col == COL_LAST) begin
                        state_nxt = rows_remain ? LOAD_ROW : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((fifo_count == 2'd0) && !rd_inflight) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_cnt       <= '0;
            real_left   <= '0;
            flush_left  <= '0;
            col         <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_issue;
            if ((state == IDLE) && start) begin
                w_cnt      <= '0;
                real_left  <= num_rows;
                flush_left <= FLUSH_INIT;
            end
            if (w_take) begin
                w_cnt <= (w_cnt == W_LAST) ? '0 : w_cnt + 1'b1;
            end
            // One column counter serves both row writes and result reads.
            if (col_adv || rd_issue) begin
                col <= (col == COL_LAST) ? '0 : col + 1'b1;
            end
            if (col_adv && (col == COL_LAST)) begin
                if (real_row) begin
                    real_left <= real_left - 1'b1;
                end else begin
                    flush_left <= flush_left - 1'b1;
                end
            end
        end
    end

    result_fifo2 u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_inflight),
        .push_data (sa_out),
        .out_data  (res_data),
        .out_valid (res_valid),
        .out_ready (res_ready),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_tile_sequencer.sv
// Randomised scoreboard bench for tile_sequencer with a behavioural
// accelerator stub whose read data is a known function of (row, column).
module tb_tile_sequencer;
    import TicSAT_pkg::*;

    localparam int SA = 4;
    localparam int FR = 2 * SA - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_rows = '0;
    logic        busy, done;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] sa_in_val;
    logic [1:0]  sa_in_idx;
    command_t    sa_cmd;
    logic [31:0] sa_out = '0;

    always #5 clk = ~clk;

    tile_sequencer #(.SA_SIZE(SA), .FLUSH_ROWS(FR)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .sa_in_val(sa_in_val), .sa_in_idx(sa_in_idx), .sa_cmd(sa_cmd), .sa_out(sa_out)
    );

    typedef struct {
        command_t    cmd;
        logic [1:0]  idx;
        logic [31:0] val;
        bit          ck_idx;
        bit          ck_val;
    } exp_cmd_t;

    exp_cmd_t    cmd_q[$];
    logic [31:0] res_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned salt;
    int cyc = 0;
    int streams = 0;
    int reads = 0, pops = 0, rd_base = 0;
    int done_cnt = 0, done_cyc = 0;
    int rdy_mode = 0;
    int stall_req = 0, stall_served = 0, stall_at = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Accelerator output for global array row g, column c.
    function automatic logic [31:0] model_val(input int g, input logic [1:0] c);
        return salt ^ ((32'(g) * 32'd4 + 32'(c)) * 32'h9E3779B1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (sa_cmd == CMD_STREAM) streams <= streams + 1;
        sa_out <= (sa_cmd == CMD_READ_OUTPUT) ? model_val(streams - 1, sa_in_idx) : 32'hDEADBEEF;
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (sa_cmd == CMD_NONE) begin
                chk("idle_drive", sa_in_val | 32'(sa_in_idx), 32'd0);
            end else if (cmd_q.size() == 0) begin
                fail_now("unexpected_cmd");
            end else begin
                exp_cmd_t e;
                e = cmd_q.pop_front();
                chk("cmd", 32'(sa_cmd), 32'(e.cmd));
                if (e.ck_idx) chk("cmd_idx", 32'(sa_in_idx), 32'(e.idx));
                if (e.ck_val) chk("cmd_val", sa_in_val, e.val);
                if (sa_cmd == CMD_READ_OUTPUT) begin
                    chk("read_credit", 32'((reads - pops - rd_base) < 2), 32'd1);
                    reads++;
                end
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_data", res_data, prev_data);
            end
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) fail_now("unexpected_result");
                else chk("result", res_data, res_q.pop_front());
                pops++;
            end
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) begin
                res_ready = 1'($urandom_range(0, 1));
            end else if (rdy_mode == 2 && stall_req != stall_served && reads >= stall_at) begin
                res_ready = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                res_ready = 1'b1;
                stall_served = stall_req;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_data"}, res_data, 32'd0);
        chk({tag, "_sa_cmd"}, 32'(sa_cmd), 32'(CMD_NONE));
        chk({tag, "_sa_in_val"}, sa_in_val, 32'd0);
        chk({tag, "_sa_in_idx"}, 32'(sa_in_idx), 32'd0);
    endtask

    // Builds the input word list and pushes the expected command and result
    // streams for an n-row job starting at global array row g0.
    task automatic plan_job(input int n, input bit fixed, input int g0, output logic [31:0] words[$]);
        logic [31:0] v;
        words.delete();
        for (int i = 0; i < SA * SA; i++) begin
            v = fixed ? 32'h3F800000 : $urandom;
            words.push_back(v);
            cmd_q.push_back('{CMD_WRITE_WEIGHTS, 2'd0, v, 1'b0, 1'b1});
        end
        for (int i = 0; i < n * SA; i++) begin
            v = fixed ? 32'h40000000 : $urandom;
            words.push_back(v);
        end
        if (n > 0) begin
            for (int r = 0; r < n + FR; r++) begin
                for (int c = 0; c < SA; c++)
                    cmd_q.push_back('{CMD_WRITE_INPUT, 2'(c), (r < n) ? words[SA * SA + r * SA + c] : 32'd0, 1'b1, 1'b1});
                cmd_q.push_back('{CMD_STREAM, 2'd0, 32'd0, 1'b0, 1'b0});
                for (int c = 0; c < SA; c++) begin
                    cmd_q.push_back('{CMD_READ_OUTPUT, 2'(c), 32'd0, 1'b1, 1'b0});
                    res_q.push_back(model_val(g0 + r, 2'(c)));
                end
            end
        end
    endtask

    function automatic logic valid_pattern(input int vmode, input int t);
        if (vmode == 1) return 1'((t % 2) == 0);
        if (vmode == 2) return 1'($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    task automatic run_job(input int n, input int vmode, input int rmode,
                           input bit fixed, input bit extra_start, input bit zero_timing);
        logic [31:0] words[$];
        int k, t, d0, start_cyc;
        bit hs;
        plan_job(n, fixed, streams, words);
        rdy_mode = rmode;
        d0 = done_cnt;
        start = 1'b1;
        num_rows = 16'(n);
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        num_rows = 16'($urandom);
        k = 0;
        t = 0;
        while (k < words.size() && t < 3000) begin
            in_valid = valid_pattern(vmode, t);
            in_data  = words[k];
            start    = extra_start && (t == 20);
            if (start) num_rows = 16'd9;
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) k++;
            t++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (t >= 3000) fail_now("feed_timeout");
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 3000) fail_now("done_timeout");
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("cmds_left", 32'(cmd_q.size()), 32'd0);
        chk("results_left", 32'(res_q.size()), 32'd0);
        chk("busy_after_job", 32'(busy), 32'd0);
        if (zero_timing)
            chk("zero_row_done_latency", 32'((done_cyc - start_cyc) inside {17, 18}), 32'd1);
        cmd_q.delete();
        res_q.delete();
    endtask

    task automatic run_abort(input int n);
        logic [31:0] words[$];
        int k, t, nstep;
        bit hs;
        plan_job(n, 1'b0, streams, words);
        rdy_mode = 1;
        start = 1'b1;
        num_rows = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        t = 0;
        nstep = 0;
        while (nstep < 3 && t < 3000) begin
            in_valid = (k < words.size()) ? valid_pattern(2, t) : 1'b0;
            in_data  = (k < words.size()) ? words[k] : 32'd0;
            @(negedge clk);
            hs = in_valid && in_ready;
            if (sa_cmd == CMD_STREAM) nstep++;
            if (nstep < 3) begin
                @(posedge clk);
                #1;
                if (hs) k++;
                t++;
            end
        end
        if (t >= 3000) fail_now("abort_step_timeout");
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_job_reset");
        cmd_q.delete();
        res_q.delete();
        rd_base = reads - pops;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        salt = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_job(1, 0, 0, 1'b1, 1'b0, 1'b0);
        run_job(0, 0, 0, 1'b0, 1'b0, 1'b1);

        stall_at = reads + 6;
        stall_req++;
        run_job(2, 0, 2, 1'b0, 1'b0, 1'b0);

        run_job(3, 1, 0, 1'b0, 1'b0, 1'b0);

        run_abort(4);
        run_job(2, 2, 1, 1'b0, 1'b0, 1'b0);

        run_job(2, 0, 1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++)
            run_job($urandom_range(1, 5), 2, 1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
